// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage:
// MIPS field positions, the reset PC and the sequential PC step.
package instr_fetch_unit_pkg;

    localparam int unsigned         INSTR_W          = 32;
    localparam logic [31:0]         RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0]         PC_STEP          = 32'd4;
    localparam logic [31:0]         PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned FUNC_MSB  = 5;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JMP  = 2'd2,
        SEL_HOLD = 2'd3
    } pc_sel_e;

    // Word offset of a branch: sign-extended imm16 scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: async active-high reset to RESET_PC,
// hold enable, and word alignment enforced on every load.
module instr_fetch_unit_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hold,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_PC & PC_ALIGN_MASK;
        end else if (!i_hold) begin
            r_q <= i_d & PC_ALIGN_MASK;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle datapath: PC register, next-PC
// selection (halt > jump > taken branch > sequential) and field slicing.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halt,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero,
    input  logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic [5:0]         op,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         func,
    output logic [15:0]        imm16
);

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic [31:0] w_next_pc;
    pc_sel_e     w_sel;

    assign w_pc_plus4   = w_pc + PC_STEP;
    assign w_br_target  = w_pc_plus4 + branch_offset(instr[15:0]);
    // Jump region comes from the incremented PC, not the current one.
    assign w_jmp_target = {w_pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        w_sel = SEL_SEQ;
        if (halt) begin
            w_sel = SEL_HOLD;
        end else if (jump) begin
            w_sel = SEL_JMP;
        end else if (branch && zero) begin
            w_sel = SEL_BR;
        end
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (w_sel)
            SEL_HOLD: w_next_pc = w_pc;
            SEL_JMP:  w_next_pc = w_jmp_target;
            SEL_BR:   w_next_pc = w_br_target;
            default:  w_next_pc = w_pc_plus4;
        endcase
    end

    instr_fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .i_hold (halt),
        .i_d    (w_next_pc),
        .o_q    (w_pc)
    );

    assign pc       = w_pc;
    assign pc_plus4 = w_pc_plus4;

    assign op    = instr[OP_MSB    -: 6];
    assign rs    = instr[RS_MSB    -: 5];
    assign rt    = instr[RT_MSB    -: 5];
    assign rd    = instr[RD_MSB    -: 5];
    assign shamt = instr[SHAMT_MSB -: 5];
    assign func  = instr[FUNC_MSB  -: 6];
    assign imm16 = instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: an arithmetic PC model checked every
// negedge, plus literal expectations at the key points of each scenario.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0, jump = 1'b0, branch = 1'b0, zero = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc, pc_plus4;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] m_pc;

    instr_fetch_unit #(.RESET_PC(32'h0000_3000), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .halt(halt), .jump(jump), .branch(branch),
        .zero(zero), .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .op(op),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm16(imm16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: next PC from the priority rules with plain arithmetic.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0000_3000;
        end else if (halt) begin
            m_pc = m_pc;
        end else if (jump) begin
            m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
        end else if (branch && zero) begin
            m_pc = m_pc + 32'd4 + 32'($signed(instr[15:0]) * 4);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        check("ctrl_known", {31'd0, $isunknown({halt, jump, branch, zero})}, 32'd0);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("op", {26'd0, op}, instr >> 26);
        check("rs", {27'd0, rs}, (instr >> 21) & 32'h1F);
        check("rt", {27'd0, rt}, (instr >> 16) & 32'h1F);
        check("rd", {27'd0, rd}, (instr >> 11) & 32'h1F);
        check("shamt", {27'd0, shamt}, (instr >> 6) & 32'h1F);
        check("func", {26'd0, func}, instr & 32'h3F);
        check("imm16", {16'd0, imm16}, instr & 32'hFFFF);
    end

    task automatic step(input logic h, input logic j, input logic b, input logic z,
                        input logic [31:0] ins);
        halt = h; jump = j; branch = b; zero = z; instr = ins;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #2;
        reset = 1'b0;
        step(0, 0, 0, 0, 32'h0);
        check("post_reset_first", pc, 32'h0000_3004);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("reset_async", pc, 32'h0000_3000);
        @(posedge clk); #1;
        @(negedge clk); #2;
        reset = 1'b0;
    endtask

    initial begin
        #12 reset = 1'b0;
        #1;
        check("reset_pc", pc, 32'h0000_3000);
        check("reset_pc_plus4", pc_plus4, 32'h0000_3004);

        // Walk to 3010, then reset asynchronously mid-cycle.
        repeat (4) step(0, 0, 0, 0, 32'h0);
        check("walk_3010", pc, 32'h0000_3010);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("async_reset_midcycle", pc, 32'h0000_3000);
        @(posedge clk); #1;
        check("reset_held", pc, 32'h0000_3000);
        @(negedge clk); #2;
        reset = 1'b0;
        step(0, 0, 0, 0, 32'h0); check("plain_3004", pc, 32'h0000_3004);
        step(0, 0, 0, 0, 32'h0); check("plain_3008", pc, 32'h0000_3008);
        step(0, 0, 0, 0, 32'h0); check("plain_300C", pc, 32'h0000_300C);

        // Branch forward, backward, not taken.
        do_reset();
        step(0, 0, 1, 1, 32'h1000_0003); check("br_fwd", pc, 32'h0000_3010);
        step(0, 0, 1, 1, 32'h1000_FFFC); check("br_back", pc, 32'h0000_3004);
        step(0, 0, 1, 0, 32'h1000_FFFC); check("br_not_taken", pc, 32'h0000_3008);

        // Jump beats branch.
        do_reset();
        step(0, 1, 1, 1, 32'h0800_0C10); check("jump_over_branch", pc, 32'h0000_3040);

        // Halt drops a jump for three edges, then a plain step.
        repeat (3) step(1, 1, 0, 0, 32'h0800_1234);
        check("halt_hold", pc, 32'h0000_3040);
        step(0, 0, 0, 0, 32'h0); check("after_halt", pc, 32'h0000_3044);

        // Climb the jump regions up to 4FFF_FFFC.
        repeat (5) step(0, 1, 0, 0, 32'h0BFF_FFFF);
        check("jump_chain", pc, 32'h4FFF_FFFC);
        step(0, 1, 0, 0, 32'h0800_0000); check("jump_upper_nibble", pc, 32'h5000_0000);

        // Continue to EFFF_FFFC, jump to FFFF_FFEC, branch to FFFF_FFFC, wrap.
        repeat (10) step(0, 1, 0, 0, 32'h0BFF_FFFF);
        check("jump_region_E", pc, 32'hEFFF_FFFC);
        step(0, 1, 0, 0, 32'h0BFF_FFFB); check("jump_FFEC", pc, 32'hFFFF_FFEC);
        step(0, 0, 1, 1, 32'h1000_0003); check("branch_FFFC", pc, 32'hFFFF_FFFC);
        check("plus4_wrap", pc_plus4, 32'h0000_0000);
        step(0, 0, 0, 0, 32'h0043_2820); check("pc_wrap", pc, 32'h0000_0000);
        #2;
        check("f_op", {26'd0, op}, 32'd0);
        check("f_rs", {27'd0, rs}, 32'd2);
        check("f_rt", {27'd0, rt}, 32'd3);
        check("f_rd", {27'd0, rd}, 32'd5);
        check("f_shamt", {27'd0, shamt}, 32'd0);
        check("f_func", {26'd0, func}, 32'h20);

        // Backward branch that crosses zero wraps modulo 2^32.
        step(0, 0, 1, 1, 32'h1000_FFFE); check("br_wrap_back", pc, 32'hFFFF_FFFC);

        @(negedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
